// File: rtl/logic_unit_if.sv
// logic_unit_if: issue/result handshake bundle for logic_unit_seq; out_parity exists only when LOGIC_UNIT_PARITY_EN is defined
interface logic_unit_if #(parameter int WIDTH = 64);
    logic in_valid, in_ready, out_valid, out_ready, out_zero;
    logic [WIDTH-1:0] in_a, in_b, out_result;
    logic [2:0] in_op;
`ifdef LOGIC_UNIT_PARITY_EN
    logic out_parity;
    modport master(output in_valid, in_a, in_b, in_op, out_ready,
                   input in_ready, out_valid, out_result, out_zero, out_parity);
    modport slave(input in_valid, in_a, in_b, in_op, out_ready,
                  output in_ready, out_valid, out_result, out_zero, out_parity);
`else
    modport master(output in_valid, in_a, in_b, in_op, out_ready,
                   input in_ready, out_valid, out_result, out_zero);
    modport slave(input in_valid, in_a, in_b, in_op, out_ready,
                  output in_ready, out_valid, out_result, out_zero);
`endif
endinterface

// File: rtl/logic_unit_seq.sv
// logic_unit_seq: slice-serial 8-op bitwise logic lane with valid/ready handshakes and zero flag
// LOGIC_UNIT_PARITY_EN adds a registered out_parity of the final result.
module logic_unit_seq #(
    parameter int WIDTH = 64,
    parameter int SLICE = 16
) (
    input logic clk,
    input logic rst_n,
    logic_unit_if.slave bus
);
    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW = NSLICE > 1 ? $clog2(NSLICE) : 1;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, full;
    logic [2:0] op_q, op_d;
    logic zero_q, zero_d;
    logic accept, last, retire;
    assign accept = state_q == IDLE && bus.in_valid;
    assign last = state_q == BUSY && cnt_q == CW'(NSLICE - 1);
    assign retire = state_q == DONE && bus.out_ready;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else state_q <= state_d;
    end
    always_comb begin
        state_d = accept ? BUSY : last ? DONE : retire ? IDLE : state_q;
    end
    always_comb begin
        bus.in_ready = state_q == IDLE;
        bus.out_valid = state_q == DONE;
        bus.out_result = res_q;
        bus.out_zero = zero_q;
    end
    always_comb begin
        full = '0;
        case (op_q)
            3'd0: full = a_q & b_q;
            3'd1: full = a_q | b_q;
            3'd2: full = a_q ^ b_q;
            3'd3: full = ~(a_q & b_q);
            3'd4: full = ~(a_q | b_q);
            3'd5: full = ~(a_q ^ b_q);
            3'd6: full = a_q & ~b_q;
            default: full = a_q;
        endcase
    end
    // only the current slice of the full-width op result is committed each cycle
    always_comb begin
        a_d = accept ? bus.in_a : a_q;
        b_d = accept ? bus.in_b : b_q;
        op_d = accept ? bus.in_op : op_q;
        cnt_d = accept ? '0 : state_q == BUSY ? cnt_q + 1'b1 : cnt_q;
        res_d = res_q;
        if (accept) res_d = '0;
        else if (state_q == BUSY) res_d[int'(cnt_q)*SLICE +: SLICE] = full[int'(cnt_q)*SLICE +: SLICE];
        zero_d = last ? res_d == '0 : retire ? 1'b0 : zero_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            a_q <= '0;
            b_q <= '0;
            op_q <= '0;
            res_q <= '0;
            zero_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            a_q <= a_d;
            b_q <= b_d;
            op_q <= op_d;
            res_q <= res_d;
            zero_q <= zero_d;
        end
    end
`ifdef LOGIC_UNIT_PARITY_EN
    logic par_q, par_d;
    always_comb begin
        par_d = last ? ^res_d : retire ? 1'b0 : par_q;
        bus.out_parity = par_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) par_q <= 1'b0;
        else par_q <= par_d;
    end
`endif
endmodule

// File: tb/tb_logic_unit_seq.sv
// tb_logic_unit_seq: directed table, corner sequences and randomized reference-model checks over three configurations
module tb_logic_unit_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;
    logic [63:0] a, b;
    logic [2:0] op;
    logic out_ready;
    logic iv [3];
    logic rdy [3], vld [3], zer [3], par [3];
    logic [63:0] res [3];
    int vecs = 0, errs = 0;
    localparam int W [3] = '{64, 8, 32};
    localparam int NS [3] = '{4, 1, 8};
    localparam logic [3:0] TT [8] = '{4'b1000, 4'b1110, 4'b0110, 4'b0111, 4'b0001, 4'b1001, 4'b0100, 4'b1100};

    logic_unit_if #(.WIDTH(64)) i64();
    logic_unit_if #(.WIDTH(8)) i8();
    logic_unit_if #(.WIDTH(32)) i32();
    logic_unit_seq #(.WIDTH(64), .SLICE(16)) u64(.clk(clk), .rst_n(rst_n), .bus(i64.slave));
    logic_unit_seq #(.WIDTH(8), .SLICE(8)) u8(.clk(clk), .rst_n(rst_n), .bus(i8.slave));
    logic_unit_seq #(.WIDTH(32), .SLICE(4)) u32(.clk(clk), .rst_n(rst_n), .bus(i32.slave));

    assign i64.in_valid = iv[0];
    assign i8.in_valid = iv[1];
    assign i32.in_valid = iv[2];
    assign i64.in_a = a;
    assign i8.in_a = a[7:0];
    assign i32.in_a = a[31:0];
    assign i64.in_b = b;
    assign i8.in_b = b[7:0];
    assign i32.in_b = b[31:0];
    assign i64.in_op = op;
    assign i8.in_op = op;
    assign i32.in_op = op;
    assign i64.out_ready = out_ready;
    assign i8.out_ready = out_ready;
    assign i32.out_ready = out_ready;
    assign rdy[0] = i64.in_ready;
    assign rdy[1] = i8.in_ready;
    assign rdy[2] = i32.in_ready;
    assign vld[0] = i64.out_valid;
    assign vld[1] = i8.out_valid;
    assign vld[2] = i32.out_valid;
    assign zer[0] = i64.out_zero;
    assign zer[1] = i8.out_zero;
    assign zer[2] = i32.out_zero;
    assign res[0] = i64.out_result;
    assign res[1] = {56'd0, i8.out_result};
    assign res[2] = {32'd0, i32.out_result};
`ifdef LOGIC_UNIT_PARITY_EN
    assign par[0] = i64.out_parity;
    assign par[1] = i8.out_parity;
    assign par[2] = i32.out_parity;
`else
    assign par[0] = 1'b0;
    assign par[1] = 1'b0;
    assign par[2] = 1'b0;
`endif

    typedef struct {
        logic [63:0] a, b;
        logic [2:0] op;
        logic [63:0] r;
        logic z, p;
    } vec_t;
    vec_t tbl [9];

    // each op is its 2-input truth table indexed by {a_bit, b_bit}
    function automatic logic [63:0] model(input logic [63:0] x, input logic [63:0] y, input logic [2:0] o, input int w);
        logic [3:0] tt;
        logic [63:0] r;
        tt = TT[o];
        r = '0;
        for (int i = 0; i < w; i++) r[i] = tt[{x[i], y[i]}];
        return r;
    endfunction

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic issue(input int s, input logic [63:0] x, input logic [63:0] y, input logic [2:0] o, output int lat);
        chk("idle_ready", 64'(rdy[s]), 64'd1);
        a = x;
        b = y;
        op = o;
        iv[s] = 1'b1;
        @(posedge clk);
        #1;
        iv[s] = 1'b0;
        a = ~x;
        b = ~y;
        op = o + 3'd1;
        chk("clear_at_accept", res[s], 64'd0);
        lat = 0;
        while (!vld[s] && lat < 64) begin
            chk("busy_ready", 64'(rdy[s]), 64'd0);
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic consume(input int s);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("retire_valid", 64'(vld[s]), 64'd0);
        chk("retire_ready", 64'(rdy[s]), 64'd1);
    endtask

    task automatic check_op(input int s, input logic [63:0] x, input logic [63:0] y, input logic [2:0] o);
        logic [63:0] e;
        int lat;
        e = model(x, y, o, W[s]);
        issue(s, x, y, o, lat);
        chk("latency", 64'(lat), 64'(NS[s]));
        chk("result", res[s], e);
        chk("zero", 64'(zer[s]), 64'(e == 64'd0));
`ifdef LOGIC_UNIT_PARITY_EN
        chk("parity", 64'(par[s]), 64'(^e));
`endif
        consume(s);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] held;
        int lat;
        tbl[0] = '{64'hFFFF0000FFFF0000, 64'h0F0F0F0F0F0F0F0F, 3'd0, 64'h0F0F00000F0F0000, 1'b0, 1'b0};
        tbl[1] = '{64'h123456789ABCDEF0, 64'h123456789ABCDEF0, 3'd2, 64'h0, 1'b1, 1'b0};
        tbl[2] = '{64'h0, 64'h0, 3'd4, 64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b0};
        tbl[3] = '{64'hFFFFFFFFFFFFFFFF, 64'h00000000FFFFFFFF, 3'd6, 64'hFFFFFFFF00000000, 1'b0, 1'b0};
        tbl[4] = '{64'h8000000000000001, 64'h5555AAAA5555AAAA, 3'd7, 64'h8000000000000001, 1'b0, 1'b0};
        tbl[5] = '{64'h1, 64'hFFFF, 3'd7, 64'h1, 1'b0, 1'b1};
        tbl[6] = '{64'hF0, 64'h0F, 3'd1, 64'hFF, 1'b0, 1'b0};
        tbl[7] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 3'd3, 64'h0, 1'b1, 1'b0};
        tbl[8] = '{64'h00FF, 64'h0F0F, 3'd5, 64'hFFFFFFFFFFFFF00F, 1'b0, 1'b0};
        iv[0] = 1'b0;
        iv[1] = 1'b0;
        iv[2] = 1'b0;
        a = '0;
        b = '0;
        op = '0;
        out_ready = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            chk("rst_ready", 64'(rdy[s]), 64'd1);
            chk("rst_valid", 64'(vld[s]), 64'd0);
            chk("rst_result", res[s], 64'd0);
            chk("rst_zero", 64'(zer[s]), 64'd0);
            chk("rst_parity", 64'(par[s]), 64'd0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 9; i++) begin
            issue(0, tbl[i].a, tbl[i].b, tbl[i].op, lat);
            chk("tbl_latency", 64'(lat), 64'd4);
            chk("tbl_result", res[0], tbl[i].r);
            chk("tbl_zero", 64'(zer[0]), 64'(tbl[i].z));
`ifdef LOGIC_UNIT_PARITY_EN
            chk("tbl_parity", 64'(par[0]), 64'(tbl[i].p));
`endif
            consume(0);
        end
        // result held under backpressure while stray in_valid pulses are ignored
        issue(0, 64'hFFFF0000FFFF0000, 64'h0F0F0F0F0F0F0F0F, 3'd0, lat);
        held = res[0];
        chk("bp_result", held, 64'h0F0F00000F0F0000);
        for (int i = 0; i < 5; i++) begin
            iv[0] = i[0];
            a = {$urandom, $urandom};
            op = 3'd1;
            @(posedge clk);
            #1;
            chk("bp_hold", res[0], held);
            chk("bp_valid", 64'(vld[0]), 64'd1);
            chk("bp_ready", 64'(rdy[0]), 64'd0);
        end
        iv[0] = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        iv[0] = 1'b0;
        out_ready = 1'b0;
        chk("bp_retire_valid", 64'(vld[0]), 64'd0);
        chk("bp_retire_ready", 64'(rdy[0]), 64'd1);
        repeat (6) @(posedge clk);
        #1;
        chk("bp_not_queued_valid", 64'(vld[0]), 64'd0);
        chk("bp_not_queued_ready", 64'(rdy[0]), 64'd1);
        // reset two cycles into BUSY abandons the partially built result
        a = '1;
        b = '1;
        op = 3'd0;
        iv[0] = 1'b1;
        @(posedge clk);
        #1;
        iv[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("mid_partial", res[0], 64'h00000000FFFFFFFF);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(vld[0]), 64'd0);
        chk("mid_rst_ready", 64'(rdy[0]), 64'd1);
        chk("mid_rst_result", res[0], 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_op(0, 64'd0, 64'd0, 3'd4);
        for (int s = 0; s < 3; s++)
            for (int n = 0; n < 30; n++)
                check_op(s, {$urandom, $urandom}, {$urandom, $urandom}, 3'($urandom_range(7)));
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
